// File: rtl/opsum_pack_fifo.sv
// opsum_pack_fifo: psum FIFO returning one element or PACK elements packed per pop
module opsum_pack_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PACK  = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push_en,
  input  logic [WIDTH-1:0]        push_data,
  output logic                    full,
  input  logic                    pop_en,
  input  logic                    pop_mod,
  output logic [WIDTH*PACK-1:0]   pop_data,
  output logic                    pop_valid,
  output logic                    empty,
  output logic [CW-1:0]           count,
  output logic                    ovf,
  output logic                    udf
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push_acc, pop_ok, pop_acc;
  logic [CW-1:0]         pop_n;
  logic [WIDTH*PACK-1:0] packed_data, single_data;
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign push_acc    = push_en && !full;
  assign pop_ok      = pop_mod ? count >= CW'(PACK) : count != '0;
  assign pop_acc     = pop_en && pop_ok;
  assign pop_n       = pop_acc ? (pop_mod ? CW'(PACK) : CW'(1)) : '0;
  assign single_data = {{(WIDTH*(PACK-1)){1'b0}}, mem[rd_ptr]};
  // pointer arithmetic wraps at AW bits, so packed slices straddle the end of storage naturally
  always_comb begin
    packed_data = '0;
    for (int k = 0; k < PACK; k++) packed_data[k*WIDTH +: WIDTH] = mem[rd_ptr + AW'(k)];
  end
  always_ff @(posedge clk) begin
    if (push_acc && !flush) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + (pop_mod ? AW'(PACK) : AW'(1));
        pop_data <= pop_mod ? packed_data : single_data;
      end
      count     <= count + CW'(push_acc) - pop_n;
      pop_valid <= pop_acc;
      ovf       <= ovf | (push_en & full);
      udf       <= udf | (pop_en & !pop_ok);
    end
  end
endmodule

// File: tb/tb_opsum_pack_fifo.sv
// tb_opsum_pack_fifo: directed checks of opsum_pack_fifo with WIDTH=16, DEPTH=4, PACK=2
module tb_opsum_pack_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_en = 1'b0;
  logic [15:0] push_data = '0;
  logic        pop_en = 1'b0;
  logic        pop_mod = 1'b0;
  logic        full, empty, pop_valid, ovf, udf;
  logic [31:0] pop_data;
  logic [2:0]  count;
  int tests = 0;
  int fails = 0;

  opsum_pack_fifo #(.WIDTH(16), .DEPTH(4), .PACK(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en(push_en), .push_data(push_data), .full(full),
    .pop_en(pop_en), .pop_mod(pop_mod), .pop_data(pop_data), .pop_valid(pop_valid),
    .empty(empty), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic pe, input logic [15:0] pd, input logic oe, input logic om);
    push_en = pe; push_data = pd; pop_en = oe; pop_mod = om;
    @(posedge clk); #1;
    push_en = 1'b0; pop_en = 1'b0; pop_mod = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pop_data", pop_data, 32'h0);
    chk("rst_pop_valid", pop_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);

    cyc(1, 16'hAAAA, 0, 0);
    cyc(1, 16'hBBBB, 0, 0);
    cyc(1, 16'hCCCC, 0, 0);
    cyc(1, 16'hDDDD, 0, 0);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 3'd4);
    cyc(0, 16'h0, 1, 0);
    chk("pop1_data", pop_data, 32'h0000AAAA);
    chk("pop1_valid", pop_valid, 1'b1);
    cyc(0, 16'h0, 1, 0);
    chk("pop2_data", pop_data, 32'h0000BBBB);
    chk("pop2_valid", pop_valid, 1'b1);
    cyc(0, 16'h0, 1, 0);
    chk("pop3_data", pop_data, 32'h0000CCCC);
    chk("pop3_count", count, 3'd1);
    cyc(1, 16'hEEEE, 0, 0);
    chk("idle_valid", pop_valid, 1'b0);
    cyc(0, 16'h0, 1, 1);
    chk("wrap_data", pop_data, 32'hEEEEDDDD);
    chk("wrap_valid", pop_valid, 1'b1);
    chk("wrap_count", count, 3'd0);
    chk("wrap_empty", empty, 1'b1);

    cyc(1, 16'h0101, 0, 0);
    cyc(1, 16'h0202, 0, 0);
    cyc(1, 16'h0303, 0, 0);
    cyc(1, 16'h0404, 0, 0);
    chk("ovf_pre", ovf, 1'b0);
    cyc(1, 16'h0505, 0, 0);
    chk("ovf_count", count, 3'd4);
    chk("ovf_flag", ovf, 1'b1);
    cyc(0, 16'h0, 1, 0);
    chk("ovf_first", pop_data, 32'h00000101);
    cyc(0, 16'h0, 1, 0);
    chk("ovf_second", pop_data, 32'h00000202);
    chk("ovf_sticky", ovf, 1'b1);

    cyc(1, 16'h1234, 1, 1);
    chk("pp_count", count, 3'd1);
    chk("pp_valid", pop_valid, 1'b1);
    chk("pp_data", pop_data, 32'h04040303);
    cyc(0, 16'h0, 1, 0);
    chk("pp_next", pop_data, 32'h00001234);
    chk("pp_empty", empty, 1'b1);

    cyc(1, 16'h5555, 0, 0);
    cyc(0, 16'h0, 1, 1);
    chk("udf_flag", udf, 1'b1);
    chk("udf_valid", pop_valid, 1'b0);
    chk("udf_hold", pop_data, 32'h00001234);
    chk("udf_count", count, 3'd1);
    cyc(0, 16'h0, 1, 0);
    chk("udf_single", pop_data, 32'h00005555);
    chk("udf_single_valid", pop_valid, 1'b1);

    cyc(1, 16'h0006, 0, 0);
    cyc(1, 16'h0007, 0, 0);
    cyc(1, 16'h0008, 0, 0);
    chk("pre_flush_count", count, 3'd3);
    flush = 1'b1;
    cyc(1, 16'h9999, 1, 0);
    chk("flush_count", count, 3'd0);
    chk("flush_empty", empty, 1'b1);
    chk("flush_ovf", ovf, 1'b0);
    chk("flush_udf", udf, 1'b0);
    chk("flush_valid", pop_valid, 1'b0);
    chk("flush_hold", pop_data, 32'h00005555);
    cyc(1, 16'hABCD, 0, 0);
    cyc(0, 16'h0, 1, 0);
    chk("post_flush", pop_data, 32'h0000ABCD);

    cyc(1, 16'h1111, 0, 0);
    cyc(1, 16'h2222, 0, 0);
    cyc(1, 16'h3333, 0, 0);
    cyc(1, 16'h4444, 1, 0);
    chk("burst_count", count, 3'd3);
    chk("burst_valid", pop_valid, 1'b1);
    chk("burst_data", pop_data, 32'h00001111);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 3'd0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_valid", pop_valid, 1'b0);
    chk("arst_data", pop_data, 32'h0);
    #1 rst = 1'b0;
    cyc(1, 16'h7777, 0, 0);
    chk("arst_push", count, 3'd1);
    cyc(0, 16'h0, 1, 0);
    chk("arst_pop", pop_data, 32'h00007777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
